// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared types and default parameters for the SPI bus arbiter.
//   state_t      - burst sequencer states (also exported on the debug port)
//   DEF_*        - default parameter values used by spi_bus_arbiter
package spi_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_CS_GAP  = 2;
  localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req  - request vector
//   ptr  - index with highest priority this round
//   any  - at least one request present
//   gnt  - one-hot grant of the first request at or after ptr (wrapping)
//   idx  - binary index of gnt
// No state here; the parent registers the result and advances ptr.
module rr_arbiter #(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int j;
    any = 1'b0;
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: shares one byte-level SPI master between NUM_REQ clients.
// A granted client owns the bus for a whole burst of (req_len+1) bytes and
// its chip select stays low across every byte of that burst.
//
// Ports
//   clk, rst             - clock, synchronous active-high reset
//   req/req_len/req_tx_data - per-client request, burst length, next TX byte
//   gnt                  - one-hot grant held for the burst
//   tx_pop               - client's current TX byte consumed this cycle
//   rx_valid/rx_byte/rx_id - received byte and the client that owns it
//   txn_done             - per-client pulse at normal burst end
//   err                  - pulse when a byte times out (burst aborted)
//   cs_n_out             - active-low chip select per client
//   spi_start/spi_tx_data - command to the master
//   spi_rx_data/spi_busy/spi_done - status from the master
//   state_dbg            - current sequencer state
//
// Master handshake: a byte is launched in a cycle where spi_start is high,
// which only happens while spi_busy is low; the master captures spi_tx_data
// on that edge. The byte is complete in the single cycle where spi_done is
// high, with spi_rx_data valid in that same cycle. tx_pop mirrors spi_start
// onto the granted client.
module spi_bus_arbiter
  import spi_arb_pkg::*;
#(
  parameter int  NUM_REQ = DEF_NUM_REQ,
  parameter int  LEN_W   = DEF_LEN_W,
  parameter int  CS_GAP  = DEF_CS_GAP,
  parameter int  TIMEOUT = DEF_TIMEOUT,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [NUM_REQ*8-1:0]     req_tx_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       tx_pop,
  output logic                     rx_valid,
  output logic [7:0]               rx_byte,
  output logic [IDX_W-1:0]         rx_id,
  output logic [NUM_REQ-1:0]       txn_done,
  output logic                     err,
  output logic [NUM_REQ-1:0]       cs_n_out,
  output logic                     spi_start,
  output logic [7:0]               spi_tx_data,
  input  logic [7:0]               spi_rx_data,
  input  logic                     spi_busy,
  input  logic                     spi_done,
  output state_t                   state_dbg
);

  localparam int GAP_W = 8;
  // to_cnt holds the number of cycles elapsed since spi_start; the abort is
  // registered when it reaches TIMEOUT-1 so err appears TIMEOUT cycles after
  // the start pulse. With TIMEOUT=1 the earliest possible abort is used.
  localparam logic [7:0] TO_LAST = (TIMEOUT > 1) ? 8'(TIMEOUT - 1) : 8'd1;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [NUM_REQ-1:0]   cs_n_q, cs_n_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           to_q, to_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic                 rx_valid_q, rx_valid_d;
  logic [7:0]           rx_byte_q, rx_byte_d;
  logic [IDX_W-1:0]     rx_id_q, rx_id_d;
  logic [NUM_REQ-1:0]   txn_done_q, txn_done_d;
  logic                 err_q, err_d;

  logic                 pick_any;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 end_burst;
  logic                 launch;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Start is combinational on the LAUNCH state so a byte can follow the
  // previous spi_done by a single cycle.
  assign launch = (state_q == ST_LAUNCH) && !spi_busy && !rst;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    gidx_d     = gidx_q;
    cs_n_d     = cs_n_q;
    cnt_d      = cnt_q;
    to_d       = to_q;
    gap_d      = gap_q;
    rx_valid_d = 1'b0;
    rx_byte_d  = rx_byte_q;
    rx_id_d    = rx_id_q;
    txn_done_d = '0;
    err_d      = 1'b0;
    end_burst  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          gidx_d  = pick_idx;
          cs_n_d  = ~pick_gnt;
          cnt_d   = req_len[int'(pick_idx)*LEN_W +: LEN_W];
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_LAUNCH;
      ST_LAUNCH: begin
        if (!spi_busy) begin
          to_d    = 8'd1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // spi_done is checked first so a byte finishing on the expiry
        // cycle is delivered rather than aborted.
        if (spi_done) begin
          rx_valid_d = 1'b1;
          rx_byte_d  = spi_rx_data;
          rx_id_d    = gidx_q;
          if (cnt_q == '0) begin
            end_burst  = 1'b1;
            txn_done_d = gnt_q;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = ST_LAUNCH;
          end
        end else if (to_q >= TO_LAST) begin
          err_d     = 1'b1;
          end_burst = 1'b1;
        end else begin
          to_d = to_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (gap_q == '0) state_d = ST_IDLE;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (end_burst) begin
      state_d = ST_RELEASE;
      cs_n_d  = '1;
      gnt_d   = '0;
      gap_d   = GAP_W'(CS_GAP - 1);
      ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      gidx_q     <= '0;
      cs_n_q     <= '1;
      cnt_q      <= '0;
      to_q       <= '0;
      gap_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= '0;
      rx_id_q    <= '0;
      txn_done_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      gidx_q     <= gidx_d;
      cs_n_q     <= cs_n_d;
      cnt_q      <= cnt_d;
      to_q       <= to_d;
      gap_q      <= gap_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      rx_id_q    <= rx_id_d;
      txn_done_q <= txn_done_d;
      err_q      <= err_d;
    end
  end

  assign gnt         = gnt_q;
  assign tx_pop      = launch ? gnt_q : '0;
  assign spi_start   = launch;
  assign spi_tx_data = (state_q == ST_LAUNCH) ? req_tx_data[int'(gidx_q)*8 +: 8] : 8'h00;
  assign rx_valid    = rx_valid_q;
  assign rx_byte     = rx_byte_q;
  assign rx_id       = rx_id_q;
  assign txn_done    = txn_done_q;
  assign err         = err_q;
  // Reset forces every select high in the same cycle, not at the next edge.
  assign cs_n_out    = cs_n_q | {NUM_REQ{rst}};
  assign state_dbg   = state_q;

endmodule
